// File: rtl/ir_packet_tx_if.sv
// Bus-side register view of the IR packet transmitter: start/config inputs and status/LED outputs.
interface ir_packet_tx_if #(
    parameter int NUM_FIELDS = 4,
    parameter int HCYC_W     = 12,
    parameter int UNIT_W     = 8
);
    logic                  SEND_PACKET;
    logic                  AUTO_REPEAT;
    logic [NUM_FIELDS-1:0] COMMAND;
    logic [HCYC_W-1:0]     CFG_HCYC;
    logic [UNIT_W-1:0]     CFG_START;
    logic [UNIT_W-1:0]     CFG_CARSEL;
    logic [UNIT_W-1:0]     CFG_GAP;
    logic [UNIT_W-1:0]     CFG_ASSERT;
    logic [UNIT_W-1:0]     CFG_DEASSERT;
    logic                  BUSY;
    logic                  DONE;
    logic                  IR_LED;

    modport master (
        output SEND_PACKET, AUTO_REPEAT, COMMAND, CFG_HCYC, CFG_START, CFG_CARSEL,
               CFG_GAP, CFG_ASSERT, CFG_DEASSERT,
        input  BUSY, DONE, IR_LED
    );

    modport slave (
        input  SEND_PACKET, AUTO_REPEAT, COMMAND, CFG_HCYC, CFG_START, CFG_CARSEL,
               CFG_GAP, CFG_ASSERT, CFG_DEASSERT,
        output BUSY, DONE, IR_LED
    );
endinterface

// File: rtl/ir_packet_tx.sv
// IR car-remote packet transmitter: START, GAP, CARSEL, GAP, then per command bit a mark and a gap,
// every mark gated by a square-wave carrier; BUSY/DONE handshake with optional auto-repeat.
module ir_packet_tx #(
    parameter int NUM_FIELDS = 4,
    parameter int HCYC_W     = 12,
    parameter int UNIT_W     = 8
) (
    input logic         CLK,
    input logic         RESETN,
    ir_packet_tx_if.slave bus
);
    localparam int IDX_W = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_GAP_H  = 3'd2;
    localparam logic [2:0] S_CARSEL = 3'd3;
    localparam logic [2:0] S_GAP_S  = 3'd4;
    localparam logic [2:0] S_FIELD  = 3'd5;
    localparam logic [2:0] S_GAP_F  = 3'd6;

    logic [2:0]            state_q, state_d;
    logic [HCYC_W-1:0]     hcnt_q, hcnt_d;
    logic                  carrier_q, carrier_d;
    logic [UNIT_W-1:0]     ucnt_q, ucnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [NUM_FIELDS-1:0] cmd_q, cmd_d;
    logic [HCYC_W-1:0]     hcyc_q, hcyc_d;
    logic [UNIT_W-1:0]     start_q, start_d;
    logic [UNIT_W-1:0]     carsel_q, carsel_d;
    logic [UNIT_W-1:0]     gap_q, gap_d;
    logic [UNIT_W-1:0]     asrt_q, asrt_d;
    logic [UNIT_W-1:0]     dasrt_q, dasrt_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  led_q, led_d;

    logic                  tick;
    logic                  seg_end;
    logic                  load;
    logic                  env;
    logic [UNIT_W-1:0]     seg_cfg;

    // Unit boundary is the carrier's high->low transition.
    assign tick = carrier_q && (hcnt_q == hcyc_q);

    always_comb begin
        seg_cfg = '0;
        case (state_q)
            S_START:          seg_cfg = start_q;
            S_CARSEL:         seg_cfg = carsel_q;
            S_GAP_H, S_GAP_S,
            S_GAP_F:          seg_cfg = gap_q;
            S_FIELD:          seg_cfg = cmd_q[idx_q] ? asrt_q : dasrt_q;
            default:          seg_cfg = '0;
        endcase
    end

    assign seg_end = tick && (ucnt_q == seg_cfg);
    assign env     = (state_q == S_START) || (state_q == S_CARSEL) || (state_q == S_FIELD);

    always_comb begin
        state_d   = state_q;
        hcnt_d    = hcnt_q;
        carrier_d = carrier_q;
        ucnt_d    = ucnt_q;
        idx_d     = idx_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        load      = 1'b0;

        if (state_q == S_IDLE) begin
            hcnt_d    = '0;
            carrier_d = 1'b0;
            ucnt_d    = '0;
            idx_d     = '0;
            if (bus.SEND_PACKET) begin
                load    = 1'b1;
                state_d = S_START;
                busy_d  = 1'b1;
            end
        end else begin
            if (hcnt_q == hcyc_q) begin
                hcnt_d    = '0;
                carrier_d = ~carrier_q;
            end else begin
                hcnt_d = hcnt_q + 1'b1;
            end

            if (tick) begin
                ucnt_d = seg_end ? '0 : ucnt_q + 1'b1;
                if (seg_end) begin
                    case (state_q)
                        S_START:  state_d = S_GAP_H;
                        S_GAP_H:  state_d = S_CARSEL;
                        S_CARSEL: state_d = S_GAP_S;
                        S_GAP_S:  state_d = S_FIELD;
                        S_FIELD:  state_d = S_GAP_F;
                        S_GAP_F: begin
                            if (idx_q == IDX_W'(NUM_FIELDS - 1)) begin
                                done_d = 1'b1;
                                idx_d  = '0;
                                if (bus.AUTO_REPEAT) begin
                                    load    = 1'b1;
                                    state_d = S_START;
                                end else begin
                                    state_d = S_IDLE;
                                    busy_d  = 1'b0;
                                end
                            end else begin
                                idx_d   = idx_q + 1'b1;
                                state_d = S_FIELD;
                            end
                        end
                        default:  state_d = S_IDLE;
                    endcase
                end
            end
        end

        led_d = env & carrier_q;
    end

    // Snapshot of command and timing; the live inputs are free to change mid-packet.
    always_comb begin
        cmd_d    = cmd_q;
        hcyc_d   = hcyc_q;
        start_d  = start_q;
        carsel_d = carsel_q;
        gap_d    = gap_q;
        asrt_d   = asrt_q;
        dasrt_d  = dasrt_q;
        if (load) begin
            cmd_d    = bus.COMMAND;
            hcyc_d   = bus.CFG_HCYC;
            start_d  = bus.CFG_START;
            carsel_d = bus.CFG_CARSEL;
            gap_d    = bus.CFG_GAP;
            asrt_d   = bus.CFG_ASSERT;
            dasrt_d  = bus.CFG_DEASSERT;
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q   <= S_IDLE;
            hcnt_q    <= '0;
            carrier_q <= 1'b0;
            ucnt_q    <= '0;
            idx_q     <= '0;
            cmd_q     <= '0;
            hcyc_q    <= '0;
            start_q   <= '0;
            carsel_q  <= '0;
            gap_q     <= '0;
            asrt_q    <= '0;
            dasrt_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            led_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            hcnt_q    <= hcnt_d;
            carrier_q <= carrier_d;
            ucnt_q    <= ucnt_d;
            idx_q     <= idx_d;
            cmd_q     <= cmd_d;
            hcyc_q    <= hcyc_d;
            start_q   <= start_d;
            carsel_q  <= carsel_d;
            gap_q     <= gap_d;
            asrt_q    <= asrt_d;
            dasrt_q   <= dasrt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            led_q     <= led_d;
        end
    end

    assign bus.BUSY   = busy_q;
    assign bus.DONE   = done_q;
    assign bus.IR_LED = led_q;
endmodule

// File: tb/tb_ir_packet_tx.sv
// Scoreboard bench: each accepted packet pushes its expected length, LED-high count and
// LED position signature; the monitor pops and compares on every DONE pulse.
module tb_ir_packet_tx;
    localparam int NF = 4;

    logic CLK    = 1'b0;
    logic RESETN = 1'b0;

    ir_packet_tx_if #(.NUM_FIELDS(NF), .HCYC_W(12), .UNIT_W(8)) bus ();

    ir_packet_tx #(.NUM_FIELDS(NF), .HCYC_W(12), .UNIT_W(8)) dut (
        .CLK    (CLK),
        .RESETN (RESETN),
        .bus    (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int len;
        int hi;
        int pos;
        bit rep;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks  = 0;
    int   errors  = 0;
    int   cyc     = 0;
    int   acc_hi  = 0;
    int   acc_pos = 0;
    int   idle_hi = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    // Behavioural packet model: unit = 2*(h+1) CLKs, carrier low then high, LED one CLK late.
    function automatic exp_t model(input logic [NF-1:0] c, input int h, input int s, input int cr,
                                   input int g, input int a, input int d, input bit rep);
        exp_t r;
        int   len [4+2*NF];
        bit   mk  [4+2*NF];
        int   u;
        int   t;
        u = 2 * (h + 1);
        t = 0;
        r.hi = 0; r.pos = 0; r.rep = rep;
        len[0] = s + 1;  mk[0] = 1'b1;
        len[1] = g + 1;  mk[1] = 1'b0;
        len[2] = cr + 1; mk[2] = 1'b1;
        len[3] = g + 1;  mk[3] = 1'b0;
        for (int f = 0; f < NF; f++) begin
            len[4+2*f] = c[f] ? a + 1 : d + 1; mk[4+2*f] = 1'b1;
            len[5+2*f] = g + 1;                mk[5+2*f] = 1'b0;
        end
        for (int k = 0; k < 4 + 2 * NF; k++) begin
            for (int n = 0; n < len[k]; n++) begin
                if (mk[k]) begin
                    for (int j = h + 2; j <= 2 * h + 2; j++) begin
                        r.hi++;
                        r.pos += t + j;
                    end
                end
                t += u;
            end
        end
        r.len = t;
        return r;
    endfunction

    int c_h, c_s, c_cr, c_g, c_a, c_d;
    logic [NF-1:0] c_cmd;

    task automatic apply(input logic [NF-1:0] c, input int h, input int s, input int cr,
                         input int g, input int a, input int d);
        c_cmd = c; c_h = h; c_s = s; c_cr = cr; c_g = g; c_a = a; c_d = d;
        bus.COMMAND      = c;
        bus.CFG_HCYC     = 12'(h);
        bus.CFG_START    = 8'(s);
        bus.CFG_CARSEL   = 8'(cr);
        bus.CFG_GAP      = 8'(g);
        bus.CFG_ASSERT   = 8'(a);
        bus.CFG_DEASSERT = 8'(d);
    endtask

    task automatic send(input bit rep);
        @(posedge CLK); #1;
        bus.SEND_PACKET = 1'b1;
        sb.push_back(model(c_cmd, c_h, c_s, c_cr, c_g, c_a, c_d, rep));
        @(posedge CLK); #1;
        bus.SEND_PACKET = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int maxc);
        int n;
        n = 0;
        while ((sb.size() != 0 || bus.BUSY) && n < maxc) begin
            @(negedge CLK);
            n++;
        end
        chk({tag, "_drained"}, sb.size(), 0);
        chk({tag, "_idle"}, bus.BUSY, 1'b0);
    endtask

    // Monitor: a DONE closes the current packet; the DONE cycle itself may open the next one.
    always @(negedge CLK) begin
        if (!RESETN) begin
            cyc = 0; acc_hi = 0; acc_pos = 0;
        end else begin
            if (bus.DONE) begin
                if (sb.size() == 0) begin
                    chk("done_unexpected", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("pkt_len", cyc, e.len);
                    chk("pkt_led_hi", acc_hi, e.hi);
                    chk("pkt_led_pos", acc_pos, e.pos);
                    chk("busy_at_done", bus.BUSY, e.rep);
                end
                cyc = 0; acc_hi = 0; acc_pos = 0;
            end
            if (bus.BUSY) begin
                if (bus.IR_LED) begin
                    acc_hi++;
                    acc_pos += cyc;
                end
                cyc++;
            end else if (bus.IR_LED) begin
                idle_hi++;
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.SEND_PACKET = 1'b0;
        bus.AUTO_REPEAT = 1'b0;
        apply(4'b0101, 3, 3, 1, 0, 2, 0);
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_busy", bus.BUSY, 1'b0);
        chk("rst_done", bus.DONE, 1'b0);
        chk("rst_led", bus.IR_LED, 1'b0);
        RESETN = 1'b1;

        // Basic packet, 20 units of 8 CLKs.
        send(1'b0);
        wait_drain("t1", 400);

        // Mid-packet SEND with changed inputs must be ignored.
        send(1'b0);
        repeat (48) @(posedge CLK);
        #1;
        bus.SEND_PACKET = 1'b1;
        bus.COMMAND = 4'b1010; bus.CFG_HCYC = 12'd1; bus.CFG_START = 8'd7; bus.CFG_GAP = 8'd2;
        @(posedge CLK); #1;
        bus.SEND_PACKET = 1'b0;
        wait_drain("t3", 400);

        // Auto-repeat relaunch picks up the new command at the packet boundary.
        apply(4'b0101, 3, 3, 1, 0, 2, 0);
        bus.AUTO_REPEAT = 1'b1;
        send(1'b1);
        repeat (40) @(negedge CLK);
        apply(4'b1111, 3, 3, 1, 0, 2, 0);
        sb.push_back(model(c_cmd, c_h, c_s, c_cr, c_g, c_a, c_d, 1'b0));
        n = 0;
        while (!bus.DONE && n < 400) begin
            @(negedge CLK);
            n++;
        end
        chk("t4_done_seen", bus.DONE, 1'b1);
        #1;
        bus.AUTO_REPEAT = 1'b0;
        wait_drain("t4", 600);

        // Async reset in the middle of a field mark aborts without DONE.
        apply(4'b0101, 3, 3, 1, 0, 2, 0);
        send(1'b0);
        repeat (70) @(posedge CLK);
        #1;
        chk("t5_busy_before", bus.BUSY, 1'b1);
        #1;
        RESETN = 1'b0;
        #1;
        chk("t5_rst_busy", bus.BUSY, 1'b0);
        chk("t5_rst_led", bus.IR_LED, 1'b0);
        chk("t5_rst_done", bus.DONE, 1'b0);
        void'(sb.pop_front());
        @(negedge CLK);
        @(posedge CLK); #1;
        RESETN = 1'b1;
        repeat (5) @(posedge CLK);
        send(1'b0);
        wait_drain("t5", 400);

        // Fastest carrier: one CLK per half period.
        apply(4'b1010, 0, 0, 0, 0, 1, 0);
        send(1'b0);
        wait_drain("t6", 200);

        // Larger, distinct durations for every segment type.
        apply(4'b1001, 5, 9, 4, 2, 6, 3);
        send(1'b0);
        wait_drain("t7", 1000);

        chk("idle_led_hi", idle_hi, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
